// File: rtl/mod_addsub_pipe.sv
// Purpose : multi-lane modular add/sub butterfly back-end (Kyber) with Dilithium bypass
// Latency : 2 cycles from in_valid to out_valid, one beat per cycle
// Backpr. : none; in_valid gaps appear as out_valid gaps
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        din beat valid
//   sel_a           2'b10 = AH from the per-lane delay line, else AH direct
//   mode            0 = Kyber add/sub, 1 = Dilithium bypass
//   clr             clears fill counter and err (err then reflects the current beat only)
//   din/dout        LANES lanes of {AH, AL} / {sum, diff} (or the bypassed word)
//   out_valid, err  dout valid; sticky Kyber-mode operand range error
//
// Build option: define MOD_ADDSUB_HALF_EN to halve Kyber results mod Q (INTT scaling).
module mod_addsub_pipe #(
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int LANES = 2,
  parameter int DEPTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [1:0]             sel_a,
  input  logic                   mode,
  input  logic                   clr,
  input  logic [LANES*2*W-1:0]   din,
  output logic [LANES*2*W-1:0]   dout,
  output logic                   out_valid,
  output logic                   err
);

  localparam int          FW = $clog2(DEPTH + 1);
  localparam logic [W:0]  QW = (W + 1)'(Q);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  // state
  logic [W-1:0]         r_dl [LANES][DEPTH];
  logic [FW-1:0]        r_fill;
  logic [LANES*2*W-1:0] r_s1_dat;
  logic                 r_s1_mode;
  logic                 r_v1;
  logic [LANES*2*W-1:0] r_dout;
  logic                 r_out_valid;
  logic                 r_err;

  // stage 1 combinational
  logic                 w_sel_dl;
  logic                 w_v1;
  logic                 w_viol;
  logic [LANES*2*W-1:0] w_s1_dat;
  logic [W-1:0]         w_ah_dir [LANES];

  always_comb begin
    logic [W-1:0] w_ah_sel;
    logic [W-1:0] w_al;
    w_sel_dl = (sel_a == 2'b10);
    w_s1_dat = '0;
    w_viol   = 1'b0;
    w_ah_sel = '0;
    w_al     = '0;
    for (int l = 0; l < LANES; l++) begin
      w_ah_dir[l] = din[l*2*W+W +: W];
      w_al        = din[l*2*W +: W];
      // delay-line tap is the AH accepted DEPTH beats ago
      w_ah_sel    = w_sel_dl ? r_dl[l][DEPTH-1] : w_ah_dir[l];
      w_s1_dat[l*2*W +: 2*W] = mode ? din[l*2*W +: 2*W] : {w_ah_sel, w_al};
      if (({1'b0, w_ah_sel} >= QW) || ({1'b0, w_al} >= QW))
        w_viol = 1'b1;
    end
    w_viol = w_viol & in_valid & ~mode;
    // until DEPTH beats have been accepted the delay-line tap holds stale data
    w_v1   = in_valid & ~(w_sel_dl & (r_fill < FULL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++)
        for (int d = 0; d < DEPTH; d++)
          r_dl[l][d] <= '0;
      r_fill    <= '0;
      r_s1_dat  <= '0;
      r_s1_mode <= 1'b0;
      r_v1      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // delay line advances only on accepted beats, in every mode
      if (in_valid) begin
        for (int l = 0; l < LANES; l++) begin
          r_dl[l][0] <= w_ah_dir[l];
          for (int d = 1; d < DEPTH; d++)
            r_dl[l][d] <= r_dl[l][d-1];
        end
      end
      if (clr)
        r_fill <= in_valid ? FW'(1) : '0;
      else if (in_valid && (r_fill != FULL))
        r_fill <= r_fill + FW'(1);
      if (in_valid) begin
        r_s1_dat  <= w_s1_dat;
        r_s1_mode <= mode;
      end
      r_v1 <= w_v1;
      if (clr)
        r_err <= w_viol;
      else if (w_viol)
        r_err <= 1'b1;
    end
  end

  // stage 2 combinational: modular add/sub per lane
  logic [LANES*2*W-1:0] w_s2_dat;

  always_comb begin
    logic [W:0] w_sum;
    logic [W:0] w_dif;
    w_s2_dat = r_s1_dat;
    w_sum    = '0;
    w_dif    = '0;
    if (!r_s1_mode) begin
      for (int l = 0; l < LANES; l++) begin
        w_sum = {1'b0, r_s1_dat[l*2*W+W +: W]} + {1'b0, r_s1_dat[l*2*W +: W]};
        if (w_sum >= QW)
          w_sum = w_sum - QW;
        // a borrow sets bit W; adding Q wraps back into [0, Q)
        w_dif = {1'b0, r_s1_dat[l*2*W+W +: W]} - {1'b0, r_s1_dat[l*2*W +: W]};
        if (w_dif[W])
          w_dif = w_dif + QW;
`ifdef MOD_ADDSUB_HALF_EN
        // x/2 mod Q: odd x becomes even after adding the (odd) modulus
        w_sum = w_sum[0] ? ((w_sum + QW) >> 1) : (w_sum >> 1);
        w_dif = w_dif[0] ? ((w_dif + QW) >> 1) : (w_dif >> 1);
`endif
        w_s2_dat[l*2*W +: 2*W] = {w_sum[W-1:0], w_dif[W-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1)
        r_dout <= w_s2_dat;
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Purpose : scoreboard bench for mod_addsub_pipe (W=12, Q=3329, LANES=2, DEPTH=7)
// Latency : expects each valid beat exactly 2 cycles after it is driven
// Backpr. : none; outputs are compared whenever out_valid is seen
module tb_mod_addsub_pipe;

  localparam int W = 12;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  sel_a;
  logic        mode;
  logic        clr;
  logic [47:0] din;
  logic [47:0] dout;
  logic        out_valid;
  logic        err;

  mod_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sel_a     (sel_a),
    .mode      (mode),
    .clr       (clr),
    .din       (din),
    .dout      (dout),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [47:0] dat;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // reference: one lane's Kyber result via integer mod arithmetic
  function automatic logic [23:0] kyb(input int ah, input int al);
    int s;
    int d;
    s = (ah + al) % Q;
    d = (ah - al + Q) % Q;
`ifdef MOD_ADDSUB_HALF_EN
    s = (s % 2 == 0) ? s / 2 : (s + Q) / 2;
    d = (d % 2 == 0) ? d / 2 : (d + Q) / 2;
`endif
    return {12'(s), 12'(d)};
  endfunction

  task automatic push_exp(input logic [47:0] d, input bit chk);
    exp_t e;
    e.dat = d;
    e.cyc = cyc + 2;
    e.chk = chk;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic m, input logic c,
                      input logic [23:0] l0, input logic [23:0] l1);
    in_valid = v;
    sel_a    = s;
    mode     = m;
    clr      = c;
    din      = {l1, l0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 24'd0, 24'd0);
  endtask

  // scoreboard monitor: every out_valid must match the oldest pending beat at its due cycle
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: dout=%h at cycle %0d, required no output", dout, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc) begin
          n_bad++;
          $display("FAIL latency: output at cycle %0d, required cycle %0d", cyc, mon_e.cyc);
        end else if (mon_e.chk && (dout !== mon_e.dat)) begin
          n_bad++;
          $display("FAIL dout: got %h, required %h (cycle %0d)", dout, mon_e.dat, cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_out_valid: out_valid=%b at cycle %0d, required 1", out_valid, cyc);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    n_cmp++; if (dout !== 48'd0) begin n_bad++; $display("FAIL reset_dout: got %h, required 0", dout); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b, required 0", err); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_kyber();
    logic [23:0] l0_req;
    logic [11:0] a0, b0, a1, b1;
`ifdef MOD_ADDSUB_HALF_EN
    l0_req = {12'd2000, 12'd1000};
`else
    l0_req = {12'd671, 12'd2000};
`endif
    push_exp({kyb(5, 10), kyb(3000, 1000)}, 1'b1);
    step(1'b1, 2'b00, 1'b0, 1'b0, {12'd3000, 12'd1000}, {12'd5, 12'd10});
    idle(1);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL kyber_latency2: out_valid=%b, required 1", out_valid); end
    n_cmp++; if (dout[23:0] !== l0_req) begin n_bad++; $display("FAIL kyber_lane0_const: got %h, required %h", dout[23:0], l0_req); end
    idle(1);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL kyber_single_pulse: out_valid=%b, required 0", out_valid); end
    // back-to-back beats, boundary operands first
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin a0 = 12'(Q-1); b0 = 12'(Q-1); a1 = 12'd0; b1 = 12'd0; end
      else if (i == 1) begin a0 = 12'd0; b0 = 12'(Q-1); a1 = 12'(Q-1); b1 = 12'd0; end
      else begin
        a0 = 12'($urandom_range(0, Q-1)); b0 = 12'($urandom_range(0, Q-1));
        a1 = 12'($urandom_range(0, Q-1)); b1 = 12'($urandom_range(0, Q-1));
      end
      push_exp({kyb(int'(a1), int'(b1)), kyb(int'(a0), int'(b0))}, 1'b1);
      step(1'b1, 2'b00, 1'b0, 1'b0, {a0, b0}, {a1, b1});
    end
    idle(3);
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL kyber_no_err: err=%b, required 0", err); end
  endtask

  task automatic test_bypass();
    push_exp({24'hFFFFFF, 24'h7FE000}, 1'b1);
    step(1'b1, 2'b10, 1'b1, 1'b0, 24'h7FE000, 24'hFFFFFF);
    push_exp({24'h123456, 24'hABCDEF}, 1'b1);
    step(1'b1, 2'b00, 1'b1, 1'b0, 24'hABCDEF, 24'h123456);
    idle(3);
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bypass_no_err: err=%b, required 0", err); end
  endtask

  task automatic test_delay_line();
    step(1'b0, 2'b00, 1'b0, 1'b1, 24'd0, 24'd0);  // clr: restart warm-up
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) idle(2);                        // idle cycles must not shift
      if (k == 10) begin
        push_exp({12'(k + 100), 12'd0, 12'(k), 12'd0}, 1'b1);
        step(1'b1, 2'b10, 1'b1, 1'b0, {12'(k), 12'd0}, {12'(k + 100), 12'd0});
      end else begin
        if (k >= 8) push_exp({kyb(k - 7 + 100, 0), kyb(k - 7, 0)}, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b0, {12'(k), 12'd0}, {12'(k + 100), 12'd0});
      end
    end
    idle(3);
  endtask

  task automatic test_err();
    push_exp(48'd0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, {12'd3329, 12'd0}, {12'd1, 12'd1});
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: err=%b, required 1", err); end
    idle(3);
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: err=%b, required 1", err); end
    step(1'b0, 2'b00, 1'b0, 1'b1, 24'd0, 24'd0);
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: err=%b, required 0", err); end
    // clr together with an offending beat (AL = Q in lane 1) keeps err set
    push_exp(48'd0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b1, {12'd2, 12'd3}, {12'd0, 12'd3329});
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_clr_viol: err=%b, required 1", err); end
    // clr with a clean beat: err follows that beat only
    push_exp({kyb(Q-1, Q-1), kyb(7, 9)}, 1'b1);
    step(1'b1, 2'b00, 1'b0, 1'b1, {12'd7, 12'd9}, {12'(Q-1), 12'(Q-1)});
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr_clean: err=%b, required 0", err); end
    idle(3);
  endtask

  task automatic test_rst_midstream();
    step(1'b1, 2'b00, 1'b0, 1'b0, {12'd10, 12'd20}, {12'd30, 12'd40});
    rst = 1'b1;
    step(1'b1, 2'b00, 1'b0, 1'b0, {12'd50, 12'd60}, {12'd70, 12'd80});
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || dout !== 48'd0) begin
        n_bad++; $display("FAIL rst_flush: out_valid=%b dout=%h, required 0/0", out_valid, dout);
      end
      idle(1);
    end
    // warm-up must restart: beats 1..7 silent, 8 and 9 use beats 1 and 2
    for (int k = 1; k <= 9; k++) begin
      if (k >= 8) push_exp({kyb(k - 7, 0), kyb(k - 7, 0)}, 1'b1);
      step(1'b1, 2'b10, 1'b0, 1'b0, {12'(k), 12'd0}, {12'(k), 12'd0});
    end
    idle(4);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel_a = 2'b00; mode = 1'b0; clr = 1'b0; din = '0;
    test_reset();
    test_kyber();
    test_bypass();
    test_delay_line();
    test_err();
    test_rst_midstream();
    @(negedge clk);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL drain: %0d beats pending, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
